// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline stage with valid/ready handshake, 2-entry skid buffer and flush (optional HI/LO via EX_MEM_HILO_EN)
module ex_mem_pipe #(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] NOP_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic              ex_wreg,
    input  logic [DATA_W-1:0] ex_wdata,
`ifdef EX_MEM_HILO_EN
    input  logic              ex_whilo,
    input  logic [DATA_W-1:0] ex_hi,
    input  logic [DATA_W-1:0] ex_lo,
    output logic              mem_whilo,
    output logic [DATA_W-1:0] mem_hi,
    output logic [DATA_W-1:0] mem_lo,
`endif
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_wd,
    output logic              mem_wreg,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
`ifdef EX_MEM_HILO_EN
    localparam int PW = ADDR_W + 2 + 3 * DATA_W;
`else
    localparam int PW = ADDR_W + 1 + DATA_W;
`endif
    state_t          state_q, state_d;
    logic            ready_q;
    logic [PW-1:0]   in_p, main_q, skid_q, nop_p, out_p;
    logic            acc, rel;
`ifdef EX_MEM_HILO_EN
    assign in_p  = {ex_whilo, ex_hi, ex_lo, ex_wd, ex_wreg, ex_wdata};
    assign nop_p = {1'b0, {DATA_W{1'b0}}, {DATA_W{1'b0}}, NOP_ADDR, 1'b0, {DATA_W{1'b0}}};
    assign {mem_whilo, mem_hi, mem_lo, mem_wd, mem_wreg, mem_wdata} = out_p;
`else
    assign in_p  = {ex_wd, ex_wreg, ex_wdata};
    assign nop_p = {NOP_ADDR, 1'b0, {DATA_W{1'b0}}};
    assign {mem_wd, mem_wreg, mem_wdata} = out_p;
`endif
    assign ex_ready  = ready_q;
    assign mem_valid = state_q != EMPTY;
    assign occupancy = state_q;
    assign acc       = ex_valid & ready_q;
    assign rel       = mem_valid & mem_ready;
    assign out_p     = mem_valid ? main_q : nop_p;
    // next-state: flush squashes everything, otherwise fill/drain the two entries
    always_comb begin
        state_d = flush ? EMPTY :
                  (state_q == EMPTY) ? (acc ? ONE : EMPTY) :
                  (state_q == ONE)   ? ((acc && !rel) ? FULL : (!acc && rel) ? EMPTY : ONE) :
                  (rel ? ONE : FULL);
    end
    // state and registered ready, so MEM back-pressure never reaches EX combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= state_d != FULL;
        end
    end
    // payload: main is presented to MEM, skid absorbs the beat accepted while MEM stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (state_q == FULL && rel)
                main_q <= skid_q;
            else if (acc && (state_q == EMPTY || rel))
                main_q <= in_p;
            if (acc && state_q == ONE && !rel)
                skid_q <= in_p;
        end
    end
endmodule
